instr_decode_queue: RTL

INSTR_DECODE_QUEUE -- requirements
Module: instr_decode_queue

---
 rtl/instr_decode_queue.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/instr_decode_queue.sv
// instr_decode_queue
//   Decodes raw RV32I instruction words into a compact record (type ordinal,
//   register fields, sign-extended immediate, pc) and buffers the records in a
//   small FIFO between fetch and issue.
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-high reset (highest priority)
//   flush        synchronous queue clear, e.g. on branch redirect
//   in_valid     upstream word present
//   in_instr     raw 32-bit RV32I instruction word
//   in_pc        pc of in_instr
//   in_ready     queue can accept a word this cycle (= !full)
//   out_valid    head entry valid
//   out_ready    downstream consumes the head entry
//   out_type     instruction type ordinal (LUI=0 .. AND=36, INVALID=37,
//                NOP=38, ECALL=39)
//   out_rd/out_rs1/out_rs2  register fields, 0 where the format has none
//   out_imm      sign-extended immediate, 0 for R-type/ECALL/INVALID
//   out_pc       pc of the head entry
//   illegal_cnt  saturating count of INVALID records enqueued
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready depends only on registered occupancy (no bypass from
// out_ready), and out_* depend only on registered queue state, so there is no
// combinational path from in_* to out_* or from out_ready to in_ready. Once
// out_valid is high the head entry stays unchanged until it is consumed, a
// flush, or a reset.

module instr_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_type,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [5:0] {
    T_LUI, T_AUIPC, T_JAL, T_JALR,
    T_BEQ, T_BNE, T_BLT, T_BGE, T_BLTU, T_BGEU,
    T_LB, T_LH, T_LW, T_LBU, T_LHU,
    T_SB, T_SH, T_SW,
    T_ADDI, T_SLTI, T_SLTIU, T_XORI, T_ORI, T_ANDI,
    T_SLLI, T_SRLI, T_SRAI,
    T_ADD, T_SUB, T_SLL, T_SLT, T_SLTU, T_XOR, T_SRL, T_SRA, T_OR, T_AND,
    T_INVALID, T_NOP, T_ECALL
  } instr_type_e;

  // Operand layout of a decoded word; FMT_SH is the I-type shift variant
  // whose immediate is the zero-extended shamt.
  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  typedef struct packed {
    logic [5:0]      itype;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  instr_type_e     dec_type;
  fmt_e            fmt;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  entry_t          dec;

  // Immediates: fill with the sign bit first, then overwrite the low bits,
  // which works for both XLEN=32 and XLEN=64.
  always_comb begin
    imm_i = {XLEN{in_instr[31]}};
    imm_i[11:0] = in_instr[31:20];

    imm_s = {XLEN{in_instr[31]}};
    imm_s[11:0] = {in_instr[31:25], in_instr[11:7]};

    imm_b = {XLEN{in_instr[31]}};
    imm_b[12:0] = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};

    imm_u = {XLEN{in_instr[31]}};
    imm_u[31:0] = {in_instr[31:12], 12'h000};

    imm_j = {XLEN{in_instr[31]}};
    imm_j[20:0] = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    imm_sh = '0;
    imm_sh[4:0] = in_instr[24:20];
  end

  always_comb begin
    dec_type = T_INVALID;
    fmt      = FMT_NONE;
    case (opcode)
      7'b0110111: begin dec_type = T_LUI;   fmt = FMT_U; end
      7'b0010111: begin dec_type = T_AUIPC; fmt = FMT_U; end
      7'b1101111: begin dec_type = T_JAL;   fmt = FMT_J; end
      7'b1100111: begin
        fmt = FMT_I;
        if (funct3 == 3'b000) dec_type = T_JALR;
      end
      7'b1100011: begin
        fmt = FMT_B;
        case (funct3)
          3'b000:  dec_type = T_BEQ;
          3'b001:  dec_type = T_BNE;
          3'b100:  dec_type = T_BLT;
          3'b101:  dec_type = T_BGE;
          3'b110:  dec_type = T_BLTU;
          3'b111:  dec_type = T_BGEU;
          default: dec_type = T_INVALID;
        endcase
      end
      7'b0000011: begin
        fmt = FMT_I;
        case (funct3)
          3'b000:  dec_type = T_LB;
          3'b001:  dec_type = T_LH;
          3'b010:  dec_type = T_LW;
          3'b100:  dec_type = T_LBU;
          3'b101:  dec_type = T_LHU;
          default: dec_type = T_INVALID;
        endcase
      end
      7'b0100011: begin
        fmt = FMT_S;
        case (funct3)
          3'b000:  dec_type = T_SB;
          3'b001:  dec_type = T_SH;
          3'b010:  dec_type = T_SW;
          default: dec_type = T_INVALID;
        endcase
      end
      7'b0010011: begin
        fmt = FMT_I;
        case (funct3)
          // The canonical all-zero ADDI (addi x0,x0,0) is reported as NOP.
          3'b000:  dec_type = (in_instr == 32'h0000_0013) ? T_NOP : T_ADDI;
          3'b010:  dec_type = T_SLTI;
          3'b011:  dec_type = T_SLTIU;
          3'b100:  dec_type = T_XORI;
          3'b110:  dec_type = T_ORI;
          3'b111:  dec_type = T_ANDI;
          3'b001: begin
            fmt = FMT_SH;
            if (funct7 == 7'b0000000) dec_type = T_SLLI;
          end
          3'b101: begin
            fmt = FMT_SH;
            if (funct7 == 7'b0000000)      dec_type = T_SRLI;
            else if (funct7 == 7'b0100000) dec_type = T_SRAI;
          end
          default: dec_type = T_INVALID;
        endcase
      end
      7'b0110011: begin
        fmt = FMT_R;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: dec_type = T_ADD;
          {7'b0100000, 3'b000}: dec_type = T_SUB;
          {7'b0000000, 3'b001}: dec_type = T_SLL;
          {7'b0000000, 3'b010}: dec_type = T_SLT;
          {7'b0000000, 3'b011}: dec_type = T_SLTU;
          {7'b0000000, 3'b100}: dec_type = T_XOR;
          {7'b0000000, 3'b101}: dec_type = T_SRL;
          {7'b0100000, 3'b101}: dec_type = T_SRA;
          {7'b0000000, 3'b110}: dec_type = T_OR;
          {7'b0000000, 3'b111}: dec_type = T_AND;
          default:              dec_type = T_INVALID;
        endcase
      end
      7'b1110011: begin
        // Only the exact ECALL word is legal; EBREAK, CSR ops etc. are not.
        if (in_instr == 32'h0000_0073) dec_type = T_ECALL;
      end
      default: dec_type = T_INVALID;
    endcase
    // An unrecognised word carries no operands at all.
    if (dec_type == T_INVALID) fmt = FMT_NONE;
  end

  always_comb begin
    dec       = '0;
    dec.itype = dec_type;
    dec.pc    = in_pc;
    case (fmt)
      FMT_R: begin
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
      end
      FMT_I: begin
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.imm = imm_i;
      end
      FMT_SH: begin
        dec.rd  = in_instr[11:7];
        dec.rs1 = in_instr[19:15];
        dec.imm = imm_sh;
      end
      FMT_S: begin
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.imm = imm_s;
      end
      FMT_B: begin
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.imm = imm_b;
      end
      FMT_U: begin
        dec.rd  = in_instr[11:7];
        dec.imm = imm_u;
      end
      FMT_J: begin
        dec.rd  = in_instr[11:7];
        dec.imm = imm_j;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Queue
  // ---------------------------------------------------------------------------
  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic          push_en, pop_en;
  entry_t        head;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // rst and flush override both handshakes.
  assign push_en = push && !flush && !rst;
  assign pop_en  = pop && !flush && !rst;

  // Storage is not reset; an empty queue masks it on the outputs instead.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating illegal-word counter; flush does not touch it and a push
  // discarded by flush is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (push_en && (dec_type == T_INVALID) && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  // Output fields read zero whenever the queue is empty.
  assign head     = mem[rd_ptr];
  assign out_type = out_valid ? head.itype : '0;
  assign out_rd   = out_valid ? head.rd    : '0;
  assign out_rs1  = out_valid ? head.rs1   : '0;
  assign out_rs2  = out_valid ? head.rs2   : '0;
  assign out_imm  = out_valid ? head.imm   : '0;
  assign out_pc   = out_valid ? head.pc    : '0;

endmodule
